// File: rtl/in_select_sync_pkg.sv
// Shared types and capture-mode encodings for the system-input selector.
package mc14500_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_LEVEL = 2'd0;
  localparam mode_t MODE_RISE  = 2'd1;
  localparam mode_t MODE_FALL  = 2'd2;
  localparam mode_t MODE_ANY   = 2'd3;

endpackage

// File: rtl/in_select_sync_if.sv
// Bus between the ICU side and the registered input selector.
interface in_select_sync_if #(
  parameter int CHANNELS = 8
) ();
  import mc14500_pkg::*;

  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS-1:0] x;
  logic [SEL_W-1:0]    abc;
  mode_t               mode;
  logic                inh;
  logic                dis;
  logic                rd;
  logic                z;
  logic                z_oe;

  modport master (output x, abc, mode, inh, dis, rd, input z, z_oe);
  modport slave  (input x, abc, mode, inh, dis, rd, output z, z_oe);

endinterface

// File: rtl/in_select_sync_debounce.sv
// One channel: two-flop synchroniser, debounce counter and stable bit.
// rise/fall flag the edge at which st is about to change.
module in_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic st,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             upd;

  assign upd  = (s2 != st) && (cnt == CNT_LAST);
  assign rise = upd & s2;
  assign fall = upd & ~s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      st  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= x;
      s2 <= s1;
      if (s2 == st) begin
        cnt <= '0;
      end else if (upd) begin
        st  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/in_select_sync.sv
// Registered input selector: per-channel debounce, sticky edge flags and a
// combinational address-to-output read path with inhibit and disable.
module in_select_sync
  import mc14500_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int DEBOUNCE = 4
) (
  input logic              clk,
  input logic              rst,
  in_select_sync_if.slave  bus
);

  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS-1:0] st;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] ev;
  logic [CHANNELS-1:0] clr;
  logic [CHANNELS-1:0] fl;
  logic                clr_en;
  logic                chan;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    in_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .x    (bus.x[g]),
      .st   (st[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

  always_comb begin
    ev = '0;
    case (bus.mode)
      MODE_RISE: ev = rise;
      MODE_FALL: ev = fall;
      MODE_ANY:  ev = rise | fall;
      default:   ev = '0;
    endcase
  end

  assign clr_en = bus.rd & ~bus.inh & ~bus.dis;

  // Addresses beyond the last channel match nothing: they read 0 and clear nothing.
  always_comb begin
    clr  = '0;
    chan = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.abc == i[SEL_W-1:0]) begin
        clr[i] = clr_en;
        chan   = (bus.mode == MODE_LEVEL) ? st[i] : fl[i];
      end
    end
  end

  // A set on the same edge as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fl <= '0;
    end else begin
      fl <= ev | (fl & ~clr);
    end
  end

  assign bus.z    = chan & ~bus.inh & ~bus.dis;
  assign bus.z_oe = ~bus.dis;

endmodule

// File: tb/tb_in_select_sync.sv
// Directed bench for in_select_sync: an 8-channel and a 6-channel instance.
module tb_in_select_sync;
  import mc14500_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  in_select_sync_if #(.CHANNELS(8)) b8 ();
  in_select_sync_if #(.CHANNELS(6)) b6 ();

  in_select_sync #(.CHANNELS(8), .DEBOUNCE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  in_select_sync #(.CHANNELS(6), .DEBOUNCE(4)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (b6.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b8.x = 8'hFF; b8.abc = 3'd3; b8.mode = MODE_LEVEL;
    b8.inh = 1'b0; b8.dis = 1'b0; b8.rd = 1'b0;
    b6.x = 6'h00; b6.abc = 3'd0; b6.mode = MODE_LEVEL;
    b6.inh = 1'b0; b6.dis = 1'b0; b6.rd = 1'b0;
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      total++;
      if (b8.z !== 1'b0) begin
        $display("FAIL reset_z cyc=%0d got=%b exp=0", n, b8.z); bad++;
      end
    end
    total++;
    if (b8.z_oe !== 1'b1) begin
      $display("FAIL reset_zoe got=%b exp=1", b8.z_oe); bad++;
    end
    rst = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      tick();
      total++;
      if (b8.z !== ((n >= 6) ? 1'b1 : 1'b0)) begin
        $display("FAIL release_latency tick=%0d got=%b exp=%b", n, b8.z, (n >= 6));
        bad++;
      end
    end
    b8.x = 8'h00;
    repeat (10) tick();
    total++;
    if (b8.z !== 1'b0) begin
      $display("FAIL settle_low got=%b exp=0", b8.z); bad++;
    end
  endtask

  task automatic test_level_glitch();
    b8.abc = 3'd2; b8.mode = MODE_LEVEL;
    b8.x[2] = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      if (n == 3) b8.x[2] = 1'b0;
      total++;
      if (b8.z !== 1'b0) begin
        $display("FAIL glitch3 tick=%0d got=%b exp=0", n, b8.z); bad++;
      end
    end
  endtask

  task automatic test_level_pulse();
    logic exp;
    b8.abc = 3'd2; b8.mode = MODE_LEVEL;
    b8.x[2] = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      tick();
      if (n == 4) b8.x[2] = 1'b0;
      exp = (n >= 6 && n <= 9);
      total++;
      if (b8.z !== exp) begin
        $display("FAIL pulse4 tick=%0d got=%b exp=%b", n, b8.z, exp); bad++;
      end
    end
  endtask

  task automatic test_rise_sticky();
    b8.abc = 3'd5; b8.mode = MODE_RISE;
    b8.x[5] = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      total++;
      if (b8.z !== ((n == 6) ? 1'b1 : 1'b0)) begin
        $display("FAIL rise_set tick=%0d got=%b exp=%b", n, b8.z, (n == 6)); bad++;
      end
    end
    b8.x[5] = 1'b0;
    repeat (10) tick();
    total++;
    if (b8.z !== 1'b1) begin
      $display("FAIL rise_sticky got=%b exp=1", b8.z); bad++;
    end
    b8.rd = 1'b1;
    #1;
    total++;
    if (b8.z !== 1'b1) begin
      $display("FAIL rd_cycle got=%b exp=1", b8.z); bad++;
    end
    tick();
    b8.rd = 1'b0;
    #1;
    total++;
    if (b8.z !== 1'b0) begin
      $display("FAIL rd_clear got=%b exp=0", b8.z); bad++;
    end
  endtask

  task automatic test_set_wins();
    b8.abc = 3'd1; b8.mode = MODE_ANY;
    b8.x[1] = 1'b1;
    repeat (5) tick();
    total++;
    if (b8.z !== 1'b0) begin
      $display("FAIL pre_event got=%b exp=0", b8.z); bad++;
    end
    b8.rd = 1'b1;
    tick();
    b8.rd = 1'b0;
    #1;
    total++;
    if (b8.z !== 1'b1) begin
      $display("FAIL set_wins got=%b exp=1", b8.z); bad++;
    end
  endtask

  task automatic test_inh_dis();
    b8.abc = 3'd1;
    b8.inh = 1'b1;
    #1;
    total++;
    if (b8.z !== 1'b0) begin
      $display("FAIL inh_z got=%b exp=0", b8.z); bad++;
    end
    b8.rd = 1'b1;
    tick();
    b8.rd = 1'b0; b8.inh = 1'b0;
    #1;
    total++;
    if (b8.z !== 1'b1) begin
      $display("FAIL inh_noclear got=%b exp=1", b8.z); bad++;
    end
    b8.dis = 1'b1;
    #1;
    total++;
    if (b8.z_oe !== 1'b0 || b8.z !== 1'b0) begin
      $display("FAIL dis_out got=%b%b exp=00", b8.z_oe, b8.z); bad++;
    end
    b8.rd = 1'b1;
    tick();
    b8.rd = 1'b0; b8.dis = 1'b0;
    #1;
    total++;
    if (b8.z_oe !== 1'b1 || b8.z !== 1'b1) begin
      $display("FAIL dis_noclear got=%b%b exp=11", b8.z_oe, b8.z); bad++;
    end
  endtask

  task automatic test_out_of_range();
    b6.mode = MODE_RISE;
    b6.x = 6'h3F;
    repeat (8) tick();
    for (int a = 6; a <= 7; a++) begin
      b6.abc = 3'(a);
      #1;
      total++;
      if (b6.z !== 1'b0) begin
        $display("FAIL oor_read abc=%0d got=%b exp=0", a, b6.z); bad++;
      end
    end
    b6.abc = 3'd7; b6.rd = 1'b1;
    tick();
    b6.rd = 1'b0;
    for (int a = 0; a < 6; a++) begin
      b6.abc = 3'(a);
      #1;
      total++;
      if (b6.z !== 1'b1) begin
        $display("FAIL oor_noclear ch=%0d got=%b exp=1", a, b6.z); bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_level_glitch();
    test_level_pulse();
    test_rise_sticky();
    test_set_wins();
    test_inh_dis();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/in_select_sync.md
# in_select_sync

Parametrised, registered successor to the 8-channel data selector on the MC14500 system input side. Each of CHANNELS asynchronous inputs is synchronised, debounced and optionally edge-captured into a sticky flag; the ICU addresses one channel and reads a single bit. The read path remains combinational from address to output, so the ICU sees the addressed value in the same cycle. The data selector's inhibit behaviour is retained, and a working disable/output-enable is added.

## Interface
Parameters:
- CHANNELS, 8: number of input channels, 2..64.
- DEBOUNCE, 4: consecutive cycles an input must differ from its stable value before the stable value updates; minimum 1 (1 = no filtering).
- Derived localparams: SEL_W = $clog2(CHANNELS); CNT_W = $clog2(DEBOUNCE+1).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- x  in  CHANNELS  raw asynchronous inputs.
- abc  in  SEL_W  channel address.
- mode  in  2  capture mode: 0 level, 1 rising sticky, 2 falling sticky, 3 any-edge sticky.
- inh  in  1  forces z to 0 and blocks clears.
- dis  in  1  output disable: z_oe=0, z=0, and blocks clears.
- rd  in  1  read strobe; clears the addressed sticky flag.
- z  out  1  selected data.
- z_oe  out  1  output enable for the board-level tristate driver; equals ~dis.

## Operation
- Per channel: two-flop synchroniser s1→s2; debounce counter cnt; stable bit st; sticky flag fl.
- Debounce:
  - If s2==st, cnt←0.
  - Otherwise cnt←cnt+1; when cnt==DEBOUNCE-1, st←s2 and cnt←0.
- Edge events are evaluated at the edge where st changes:
  - rise = st 0→1; fall = st 1→0.
  - Event set by mode: mode 1 uses rise; mode 2 uses fall; mode 3 uses rise|fall; mode 0 generates no events.
- A flag is set by an event on its channel.
- Flag clear: when rd=1, inh=0 and dis=0, flag fl[abc] is cleared.
  - If an event on the same channel occurs at the same edge, the set wins and fl stays 1.
- Read value: chan = st[abc] in mode 0, else fl[abc].
  - z = chan & ~inh & ~dis (combinational); z_oe = ~dis.
- An address ≥ CHANNELS reads 0, and rd at that address clears nothing.
- Mode changes take effect on the next edge. Flags are not cleared by a mode change, and they hold while mode=0.
- Reset: s1, s2, st, cnt and fl are all 0, so z=0 and z_oe=~dis.
  - An input high at reset release produces a rise event after the normal latency; this is required behaviour.
  - Reset asserted mid-debounce discards the count.

## Timing
- An input change first captured into s1 at edge k reaches s2 at edge k+1 and updates st at edge k+1+DEBOUNCE, provided the input stays stable throughout.
- A flag sets at the same edge as st changes. z reflects the change in the cycle following that edge.
- A glitch shorter than DEBOUNCE cycles at s2 resets cnt to 0 and produces no st change.
- Path from abc/inh/dis to z/z_oe: purely combinational, zero cycles.
- The rd clear takes effect at the edge where rd is sampled. z reads 1 during the rd cycle and 0 afterwards, unless a new event sets the flag.

## Structure
- Package mc14500_pkg holds the mode constants MODE_LEVEL=0, MODE_RISE=1, MODE_FALL=2, MODE_ANY=3, and the 2-bit mode typedef.
- One sub-module, in_debounce, is parametrised by DEBOUNCE. It contains one channel's synchroniser, counter and st register, and outputs st, rise and fall. It is instantiated CHANNELS times in a generate loop.
- The top level holds the flag vector, the clear logic and the read mux.

## Test plan
- Reset with x=8'hFF, mode=0, DEBOUNCE=4, release at edge 0 → st=1 from edge 5 onward (k=0: s1 at edge 0, st at edge 0+1+4); z=1 for abc=3; z=0 throughout reset.
- mode=0: 3-cycle high pulse on x[2] → z stays 0. 4-cycle high pulse → z goes high for 4 cycles after a 5-edge delay.
- mode=1: rise on x[5], then x[5] returns low → z=1 at abc=5. rd with abc=5 → z=0 on the next cycle.
- mode=3: rd on channel 1 at the same edge as a st change on channel 1 → fl[1] stays 1.
- inh=1 with flag set → z=0 and rd does not clear; dis=1 → z_oe=0, z=0 and no clear. Deassert both → z=1.
- CHANNELS=6: abc=7 → z=0, and rd at abc=7 leaves all flags unchanged.
